// File: rtl/fifo_pkt_wr.sv
// Write-side front end of the async FIFO: 2-entry skid buffer, wfull-gated write, packet framing check.
// Optional completed-packet counter is built only when WR_PKT_CNT_EN is defined.
module fifo_pkt_wr #(
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_sop,
  input  logic            in_eop,
  input  logic            flush,
  input  logic            wfull,
  output logic            wren,
  output logic [DW+1:0]   wdata,
  output logic            busy,
  output logic            pkt_err,
  output logic [CNTW-1:0] pkt_cnt
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  logic          m_valid_r, s_valid_r, in_ready_r;
  logic [DW+1:0] m_data_r, s_data_r;
  logic          m_valid_nx_s, s_valid_nx_s;
  logic [DW+1:0] m_data_nx_s, s_data_nx_s, in_word_s;
  logic          accept_s, drain_s;
  state_t        state_r, state_nx_s;
  logic          err_nx_s, pkt_err_r, busy_s;

  assign in_word_s = {in_eop, in_sop, in_data};
  assign accept_s  = in_valid & in_ready_r & ~flush;
  assign drain_s   = wren;

  // wren stays a direct function of the M flop and wfull so the RAM write path is short.
  assign wren     = m_valid_r & ~wfull;
  assign wdata    = m_data_r;
  assign in_ready = in_ready_r;
  assign pkt_err  = pkt_err_r;
  assign busy     = busy_s;

  // Skid buffer next state; in_ready mirrors "S empty", so accept never coincides with S full.
  always_comb begin
    m_valid_nx_s = m_valid_r;
    m_data_nx_s  = m_data_r;
    s_valid_nx_s = s_valid_r;
    s_data_nx_s  = s_data_r;
    if (flush) begin
      m_valid_nx_s = 1'b0;
      s_valid_nx_s = 1'b0;
    end else if (drain_s) begin
      if (s_valid_r) begin
        m_valid_nx_s = 1'b1;
        m_data_nx_s  = s_data_r;
        s_valid_nx_s = 1'b0;
      end else if (accept_s) begin
        m_valid_nx_s = 1'b1;
        m_data_nx_s  = in_word_s;
      end else begin
        m_valid_nx_s = 1'b0;
      end
    end else if (accept_s) begin
      if (m_valid_r) begin
        s_valid_nx_s = 1'b1;
        s_data_nx_s  = in_word_s;
      end else begin
        m_valid_nx_s = 1'b1;
        m_data_nx_s  = in_word_s;
      end
    end else begin
      m_valid_nx_s = m_valid_r;
    end
  end

  // Buffer registers and registered ready.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      m_data_r   <= {(DW+2){1'b0}};
      s_data_r   <= {(DW+2){1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      m_valid_r  <= m_valid_nx_s;
      s_valid_r  <= s_valid_nx_s;
      m_data_r   <= m_data_nx_s;
      s_data_r   <= s_data_nx_s;
      in_ready_r <= ~s_valid_nx_s & ~flush;
    end
  end

  // Framing FSM state register and registered error pulse.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r   <= IDLE;
      pkt_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      pkt_err_r <= err_nx_s;
    end
  end

  // Framing FSM next state: evaluated on each accepted word; a stray sop restarts the packet.
  always_comb begin
    state_nx_s = state_r;
    err_nx_s   = 1'b0;
    if (flush) begin
      state_nx_s = IDLE;
    end else if (accept_s) begin
      case (state_r)
        IDLE: begin
          err_nx_s   = ~in_sop;
          state_nx_s = (in_sop & ~in_eop) ? PKT : IDLE;
        end
        PKT: begin
          err_nx_s   = in_sop;
          state_nx_s = in_eop ? IDLE : PKT;
        end
        default: begin
          err_nx_s   = 1'b1;
          state_nx_s = IDLE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Framing FSM outputs.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      PKT:     busy_s = 1'b1;
      IDLE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

`ifdef WR_PKT_CNT_EN
  logic [CNTW-1:0] pkt_cnt_r;

  // Count packets as their eop word is written; flush does not clear it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      pkt_cnt_r <= {CNTW{1'b0}};
    end else if (wren & m_data_r[DW+1]) begin
      pkt_cnt_r <= pkt_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign pkt_cnt = pkt_cnt_r;
`else
  assign pkt_cnt = {CNTW{1'b0}};
`endif

endmodule
